alarm_ctrl: RTL

ALARM_CTRL -- requirements
Module: alarm_ctrl

---
 rtl/alarm_ctrl_if.sv | 30 +++
 rtl/alarm_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alarm_ctrl_if.sv
// Alarm controller bus: time/alarm settings and keys in, alarm status out.
interface alarm_ctrl_if;
    logic       tick_1hz;
    logic       alarm_en;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;
    logic       key_stop;
    logic       key_snooze;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    // Driver side: supplies time, settings and keys, observes status.
    modport master (
        output tick_1hz, alarm_en, cur_hour, cur_min, cur_sec,
               alm_hour, alm_min, key_stop, key_snooze,
        input  buzzer, ringing, snoozing, snooze_cnt
    );

    // Controller side.
    modport slave (
        input  tick_1hz, alarm_en, cur_hour, cur_min, cur_sec,
               alm_hour, alm_min, key_stop, key_snooze,
        output buzzer, ringing, snoozing, snooze_cnt
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: arm, ring, snooze, hold-off for the rest of the
// alarm minute. All outputs are registered from the state registers.
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    alarm_ctrl_if.slave  bus
);

    localparam int SEC_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);

    localparam logic [SEC_W-1:0] RING_LIM = SEC_W'(RING_SECS);
    localparam logic [SEC_W-1:0] SNZ_LIM  = SEC_W'(SNOOZE_SECS);
    localparam logic [SEC_W-1:0] SEC_SAT  = '1;
    localparam logic [1:0]       MAX_SN   = 2'(MAX_SNOOZE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_RING   = 3'd2;
    localparam logic [2:0] S_SNOOZE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic             beep_phase_q, beep_phase_d;
    logic             buzzer_q, buzzer_d;
    logic             ringing_q, ringing_d;
    logic             snoozing_q, snoozing_d;
    logic [1:0]       snz_out_q, snz_out_d;

    logic             match;
    logic [SEC_W-1:0] sec_inc;

    assign match   = (bus.cur_hour == bus.alm_hour) && (bus.cur_min == bus.alm_min)
                     && (bus.cur_sec == 6'd0);
    // Saturating increment so a long stall can never wrap back to zero.
    assign sec_inc = (sec_cnt_q == SEC_SAT) ? sec_cnt_q : sec_cnt_q + SEC_W'(1);

    // Next-state: enable drop overrides everything; key events beat ticks.
    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        beep_phase_d = beep_phase_q;
        if (!bus.alarm_en) begin
            state_d      = S_IDLE;
            sec_cnt_d    = '0;
            snooze_cnt_d = '0;
            beep_phase_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARMED;
                S_ARMED: begin
                    if (match) begin
                        state_d      = S_RING;
                        sec_cnt_d    = '0;
                        beep_phase_d = 1'b0;
                        snooze_cnt_d = '0;
                    end
                end
                S_RING: begin
                    if (bus.key_stop || (bus.key_snooze && snooze_cnt_q >= MAX_SN)) begin
                        state_d = S_HOLD;
                    end else if (bus.key_snooze) begin
                        state_d      = S_SNOOZE;
                        snooze_cnt_d = snooze_cnt_q + 2'd1;
                        sec_cnt_d    = '0;
                    end else if (bus.tick_1hz) begin
                        sec_cnt_d    = sec_inc;
                        beep_phase_d = ~beep_phase_q;
                        if (sec_inc >= RING_LIM) state_d = S_HOLD;
                    end
                end
                S_SNOOZE: begin
                    if (bus.key_stop) begin
                        state_d = S_HOLD;
                    end else if (bus.tick_1hz) begin
                        sec_cnt_d = sec_inc;
                        if (sec_inc >= SNZ_LIM) begin
                            state_d   = S_RING;
                            sec_cnt_d = '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.cur_min != bus.alm_min) state_d = S_ARMED;
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Every ring period starts with the buzzer off.
        if (state_d != S_RING) beep_phase_d = 1'b0;
    end

    // Output decode from the current state; registered, so one clk behind.
    always_comb begin
        buzzer_d   = (state_q == S_RING) && beep_phase_q;
        ringing_d  = (state_q == S_RING);
        snoozing_d = (state_q == S_SNOOZE);
        snz_out_d  = snooze_cnt_q;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sec_cnt_q    <= '0;
            snooze_cnt_q <= '0;
            beep_phase_q <= 1'b0;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
            snz_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            sec_cnt_q    <= sec_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            beep_phase_q <= beep_phase_d;
            buzzer_q     <= buzzer_d;
            ringing_q    <= ringing_d;
            snoozing_q   <= snoozing_d;
            snz_out_q    <= snz_out_d;
        end
    end

    assign bus.buzzer     = buzzer_q;
    assign bus.ringing    = ringing_q;
    assign bus.snoozing   = snoozing_q;
    assign bus.snooze_cnt = snz_out_q;

endmodule
